// File: rtl/controlador_temporizacao_if.sv
// Condition bus between the timing generator and the lamp-mode FSM.
`timescale 1ns/1ps
interface controlador_temporizacao_if;
  logic push_button;
  logic infrared;
  logic en_tc;
  logic a;
  logic b;
  logic c;
  logic d;

  modport master (
    output push_button,
    output infrared,
    output en_tc,
    input  a,
    input  b,
    input  c,
    input  d
  );

  modport slave (
    input  push_button,
    input  infrared,
    input  en_tc,
    output a,
    output b,
    output c,
    output d
  );
endinterface

// File: rtl/controlador_temporizacao.sv
// Button debounce and press-duration measurement, no-presence timer and
// synchronized presence level feeding the lamp-mode FSM conditions a/b/c/d.
`timescale 1ns/1ps
module controlador_temporizacao #(
  parameter int unsigned DEBOUNCE_CYC = 20,
  parameter int unsigned SHORT_CYC    = 300,
  parameter int unsigned LONG_CYC     = 5000,
  parameter int unsigned IDLE_CYC     = 30000
) (
  input logic clk,
  input logic rst,
  controlador_temporizacao_if.slave bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned TP_W = $clog2(LONG_CYC + 1);
  localparam int unsigned TC_W = $clog2(IDLE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } press_state_t;

  logic            btn_s1, btn_s2;
  logic            ir_s1, ir_s2;
  logic            btn_db, btn_db_q;
  logic [DB_W-1:0] cnt_db;
  logic [TP_W-1:0] tp;
  logic [TC_W-1:0] tc;
  logic            a_q, b_q, c_q;
  press_state_t    state;

  // Two-flop synchronizers for both asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      ir_s1  <= 1'b0;
      ir_s2  <= 1'b0;
    end else begin
      btn_s1 <= bus.push_button;
      btn_s2 <= btn_s1;
      ir_s1  <= bus.infrared;
      ir_s2  <= ir_s1;
    end
  end

  // Debounced level only moves after DEBOUNCE_CYC consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_db <= '0;
      btn_db <= 1'b0;
    end else if (btn_s2 == btn_db) begin
      cnt_db <= '0;
    end else if (cnt_db == DB_W'(DEBOUNCE_CYC - 1)) begin
      cnt_db <= '0;
      btn_db <= ~btn_db;
    end else begin
      cnt_db <= cnt_db + DB_W'(1);
    end
  end

  // Press FSM: Tp measures debounced hold time; a/b are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tp       <= '0;
      btn_db_q <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_db && !btn_db_q) begin
            state <= PRESSED;
            tp    <= '0;
          end
        end
        PRESSED: begin
          if (btn_db) begin
            if (tp == TP_W'(LONG_CYC - 1)) begin
              a_q   <= 1'b1;
              state <= LONG_HELD;
            end else begin
              tp <= tp + TP_W'(1);
            end
          end else begin
            b_q   <= (tp > TP_W'(SHORT_CYC));
            state <= IDLE;
          end
        end
        LONG_HELD: begin
          if (!btn_db) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No-presence timer; presence or disable takes priority over expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc  <= '0;
      c_q <= 1'b0;
    end else if (!bus.en_tc || ir_s2) begin
      tc  <= '0;
      c_q <= 1'b0;
    end else if (tc == TC_W'(IDLE_CYC - 1)) begin
      tc  <= '0;
      c_q <= 1'b1;
    end else begin
      tc  <= tc + TC_W'(1);
      c_q <= 1'b0;
    end
  end

  assign bus.a = a_q;
  assign bus.b = b_q;
  assign bus.c = c_q;
  assign bus.d = ir_s2;

endmodule
